// File: rtl/mem_dma.sv
// Byte-granular DMA initiator: copies a source range to a destination range or
// fills a destination range with a constant byte, one memory access per cycle.
module mem_dma #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  mode,
  input  logic [ADDR_WIDTH-1:0] src_addr,
  input  logic [ADDR_WIDTH-1:0] dst_addr,
  input  logic [ADDR_WIDTH-1:0] length,
  input  logic [DATA_WIDTH-1:0] fill_value,
  output logic [ADDR_WIDTH-1:0] mem_address,
  output logic                  mem_write_enable,
  output logic [DATA_WIDTH-1:0] mem_write_data,
  input  logic [DATA_WIDTH-1:0] mem_data,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_WIDTH-1:0] remaining
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_WRITE = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam logic [ADDR_WIDTH-1:0] ONE_C = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

  state_t                  state_r, state_nxt_s;
  logic                    mode_r, mode_nxt_s;
  logic [DATA_WIDTH-1:0]   fill_r, fill_nxt_s;
  logic [ADDR_WIDTH-1:0]   src_ptr_r, src_ptr_nxt_s;
  logic [ADDR_WIDTH-1:0]   dst_ptr_r, dst_ptr_nxt_s;
  logic [ADDR_WIDTH-1:0]   remaining_nxt_s;
  logic [DATA_WIDTH-1:0]   buf_r, buf_nxt_s;

  logic [ADDR_WIDTH-1:0]   address_nxt_s;
  logic                    write_enable_nxt_s;
  logic [DATA_WIDTH-1:0]   write_data_nxt_s;
  logic                    busy_nxt_s;
  logic                    done_nxt_s;

  // Next-state, pointer and buffer update for the transfer sequencer.
  always_comb begin
    state_nxt_s     = state_r;
    mode_nxt_s      = mode_r;
    fill_nxt_s      = fill_r;
    src_ptr_nxt_s   = src_ptr_r;
    dst_ptr_nxt_s   = dst_ptr_r;
    remaining_nxt_s = remaining;
    buf_nxt_s       = buf_r;
    case (state_r)
      ST_IDLE: begin
        if (start) begin
          mode_nxt_s      = mode;
          fill_nxt_s      = fill_value;
          src_ptr_nxt_s   = src_addr;
          dst_ptr_nxt_s   = dst_addr;
          remaining_nxt_s = length;
          if (length == {ADDR_WIDTH{1'b0}}) begin
            state_nxt_s = ST_DONE;
          end else if (mode == 1'b0) begin
            state_nxt_s = ST_READ;
          end else begin
            state_nxt_s = ST_WRITE;
          end
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_READ: begin
        buf_nxt_s     = mem_data;
        src_ptr_nxt_s = src_ptr_r + ONE_C;
        state_nxt_s   = ST_WRITE;
      end
      ST_WRITE: begin
        dst_ptr_nxt_s   = dst_ptr_r + ONE_C;
        remaining_nxt_s = remaining - ONE_C;
        if (remaining == ONE_C) begin
          state_nxt_s = ST_DONE;
        end else if (mode_r == 1'b0) begin
          state_nxt_s = ST_READ;
        end else begin
          state_nxt_s = ST_WRITE;
        end
      end
      ST_DONE: begin
        state_nxt_s = ST_IDLE;
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // Memory-side outputs for the upcoming cycle, so they leave the block registered.
  always_comb begin
    address_nxt_s      = {ADDR_WIDTH{1'b0}};
    write_enable_nxt_s = 1'b0;
    write_data_nxt_s   = {DATA_WIDTH{1'b0}};
    busy_nxt_s         = 1'b0;
    done_nxt_s         = 1'b0;
    case (state_nxt_s)
      ST_IDLE: begin
        busy_nxt_s = 1'b0;
      end
      ST_READ: begin
        address_nxt_s = src_ptr_nxt_s;
        busy_nxt_s    = 1'b1;
      end
      ST_WRITE: begin
        address_nxt_s      = dst_ptr_nxt_s;
        write_enable_nxt_s = 1'b1;
        write_data_nxt_s   = mode_nxt_s ? fill_nxt_s : buf_nxt_s;
        busy_nxt_s         = 1'b1;
      end
      ST_DONE: begin
        busy_nxt_s = 1'b1;
        done_nxt_s = 1'b1;
      end
      default: begin
        busy_nxt_s = 1'b0;
      end
    endcase
  end

  // State, pointers and output registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r          <= ST_IDLE;
      mode_r           <= 1'b0;
      fill_r           <= {DATA_WIDTH{1'b0}};
      src_ptr_r        <= {ADDR_WIDTH{1'b0}};
      dst_ptr_r        <= {ADDR_WIDTH{1'b0}};
      remaining        <= {ADDR_WIDTH{1'b0}};
      buf_r            <= {DATA_WIDTH{1'b0}};
      mem_address      <= {ADDR_WIDTH{1'b0}};
      mem_write_enable <= 1'b0;
      mem_write_data   <= {DATA_WIDTH{1'b0}};
      busy             <= 1'b0;
      done             <= 1'b0;
    end else begin
      state_r          <= state_nxt_s;
      mode_r           <= mode_nxt_s;
      fill_r           <= fill_nxt_s;
      src_ptr_r        <= src_ptr_nxt_s;
      dst_ptr_r        <= dst_ptr_nxt_s;
      remaining        <= remaining_nxt_s;
      buf_r            <= buf_nxt_s;
      mem_address      <= address_nxt_s;
      mem_write_enable <= write_enable_nxt_s;
      mem_write_data   <= write_data_nxt_s;
      busy             <= busy_nxt_s;
      done             <= done_nxt_s;
    end
  end

endmodule

// File: tb/tb_mem_dma.sv
// Directed bench for mem_dma with a behavioural single-port memory and
// hand-computed expected memory contents and cycle counts.
module tb_mem_dma;

  logic       clock;
  logic       reset;
  logic       start;
  logic       mode;
  logic [7:0] src_addr;
  logic [7:0] dst_addr;
  logic [7:0] length;
  logic [7:0] fill_value;
  logic [7:0] mem_address;
  logic       mem_write_enable;
  logic [7:0] mem_write_data;
  logic [7:0] mem_data;
  logic       busy;
  logic       done;
  logic [7:0] remaining;

  logic [7:0] mem [256];
  int check_cnt;
  int fail_cnt;
  int busy_cnt;
  int done_cnt;
  int we_cnt;

  mem_dma #(.ADDR_WIDTH(8), .DATA_WIDTH(8)) dut (
    .clock(clock), .reset(reset), .start(start), .mode(mode),
    .src_addr(src_addr), .dst_addr(dst_addr), .length(length),
    .fill_value(fill_value), .mem_address(mem_address),
    .mem_write_enable(mem_write_enable), .mem_write_data(mem_write_data),
    .mem_data(mem_data), .busy(busy), .done(done), .remaining(remaining)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Single-port memory: combinational read, write on the rising edge.
  assign mem_data = mem[mem_address];
  always @(posedge clock) begin
    if (mem_write_enable) mem[mem_address] <= mem_write_data;
  end

  task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
    check_cnt++;
    if (got !== exp) begin
      fail_cnt++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Launches one transfer and runs it to completion, optionally re-asserting
  // start with a conflicting request while the engine is busy.
  task automatic run_op(input logic m, input logic [7:0] src, input logic [7:0] dst,
                        input logic [7:0] len, input logic [7:0] fv, input logic poke);
    bit finished;
    finished = 1'b0;
    busy_cnt = 0;
    done_cnt = 0;
    we_cnt   = 0;
    @(negedge clock);
    mode = m; src_addr = src; dst_addr = dst; length = len; fill_value = fv;
    start = 1'b1;
    for (int i = 0; i < 600; i++) begin
      @(negedge clock);
      start = 1'b0;
      if (busy) busy_cnt++;
      if (done) done_cnt++;
      if (mem_write_enable) we_cnt++;
      if (poke && i == 0) begin
        start = 1'b1; mode = 1'b1; dst_addr = 8'h00; src_addr = 8'h00;
        length = 8'd9; fill_value = 8'hEE;
      end
      if (!busy && i > 0) begin
        finished = 1'b1;
        break;
      end
    end
    start = 1'b0;
    check_value("op_timeout", {31'd0, finished}, 32'd1);
  endtask

  initial begin
    check_cnt = 0; fail_cnt = 0;
    for (int a = 0; a < 256; a++) mem[a] = 8'h00;
    reset = 1'b1; start = 1'b0; mode = 1'b0;
    src_addr = 8'h00; dst_addr = 8'h00; length = 8'h00; fill_value = 8'h00;
    repeat (2) @(posedge clock);
    @(negedge clock);
    check_value("rst_busy", {31'd0, busy}, 32'd0);
    check_value("rst_done", {31'd0, done}, 32'd0);
    check_value("rst_we", {31'd0, mem_write_enable}, 32'd0);
    check_value("rst_addr", {24'd0, mem_address}, 32'd0);
    check_value("rst_wdata", {24'd0, mem_write_data}, 32'd0);
    check_value("rst_rem", {24'd0, remaining}, 32'd0);
    reset = 1'b0;

    // Copy of four bytes, with a conflicting start injected while busy.
    mem[8'h10] = 8'h01; mem[8'h11] = 8'h02; mem[8'h12] = 8'h03; mem[8'h13] = 8'h04;
    run_op(1'b0, 8'h10, 8'h80, 8'd4, 8'h00, 1'b1);
    check_value("copy_busy", busy_cnt, 32'd9);
    check_value("copy_done", done_cnt, 32'd1);
    check_value("copy_we", we_cnt, 32'd4);
    for (int k = 0; k < 4; k++) begin
      check_value("copy_dst", {24'd0, mem[8'h80 + k]}, 32'(k + 1));
      check_value("copy_src", {24'd0, mem[8'h10 + k]}, 32'(k + 1));
    end
    check_value("copy_rem", {24'd0, remaining}, 32'd0);
    check_value("poke_ignored", {24'd0, mem[8'h00]}, 32'h00);

    // Fill of three bytes; the neighbour must stay intact.
    mem[8'h23] = 8'h5C;
    run_op(1'b1, 8'h00, 8'h20, 8'd3, 8'hAA, 1'b0);
    check_value("fill_busy", busy_cnt, 32'd4);
    check_value("fill_done", done_cnt, 32'd1);
    for (int k = 0; k < 3; k++) check_value("fill_dst", {24'd0, mem[8'h20 + k]}, 32'hAA);
    check_value("fill_edge", {24'd0, mem[8'h23]}, 32'h5C);

    // Zero length, with a start re-asserted during the DONE cycle.
    run_op(1'b1, 8'h00, 8'h60, 8'd0, 8'h33, 1'b1);
    check_value("zero_busy", busy_cnt, 32'd1);
    check_value("zero_done", done_cnt, 32'd1);
    check_value("zero_we", we_cnt, 32'd0);
    repeat (3) @(negedge clock);
    check_value("zero_idle", {31'd0, busy}, 32'd0);
    check_value("zero_poke", {24'd0, mem[8'h00]}, 32'h00);

    // Copy across the top of the address space.
    mem[8'hFE] = 8'h11; mem[8'hFF] = 8'h22; mem[8'h00] = 8'h33; mem[8'h01] = 8'h44;
    run_op(1'b0, 8'hFE, 8'h7F, 8'd4, 8'h00, 1'b0);
    check_value("wrap_busy", busy_cnt, 32'd9);
    check_value("wrap_7f", {24'd0, mem[8'h7F]}, 32'h11);
    check_value("wrap_80", {24'd0, mem[8'h80]}, 32'h22);
    check_value("wrap_81", {24'd0, mem[8'h81]}, 32'h33);
    check_value("wrap_82", {24'd0, mem[8'h82]}, 32'h44);

    run_op(1'b1, 8'h00, 8'hFF, 8'd2, 8'h99, 1'b0);
    check_value("wfill_ff", {24'd0, mem[8'hFF]}, 32'h99);
    check_value("wfill_00", {24'd0, mem[8'h00]}, 32'h99);
    check_value("wfill_01", {24'd0, mem[8'h01]}, 32'h44);

    // Overlapping copy replicates the first byte.
    mem[8'h40] = 8'h5A; mem[8'h41] = 8'hC3;
    run_op(1'b0, 8'h40, 8'h41, 8'd3, 8'h00, 1'b0);
    check_value("ovl_40", {24'd0, mem[8'h40]}, 32'h5A);
    for (int k = 1; k < 4; k++) check_value("ovl_dst", {24'd0, mem[8'h40 + k]}, 32'h5A);

    // Reset during the second WRITE of a five-byte fill.
    for (int k = 0; k < 6; k++) mem[8'h50 + k] = 8'h00;
    @(negedge clock);
    mode = 1'b1; dst_addr = 8'h50; length = 8'd5; fill_value = 8'h77; start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    check_value("rmid_we1", {31'd0, mem_write_enable}, 32'd1);
    @(negedge clock);
    check_value("rmid_we2", {24'd0, mem_address}, 32'h51);
    reset = 1'b1;
    @(negedge clock);
    check_value("rmid_busy", {31'd0, busy}, 32'd0);
    check_value("rmid_we", {31'd0, mem_write_enable}, 32'd0);
    check_value("rmid_rem", {24'd0, remaining}, 32'd0);
    reset = 1'b0;
    repeat (3) @(negedge clock);
    check_value("rmid_m50", {24'd0, mem[8'h50]}, 32'h77);
    check_value("rmid_m51", {24'd0, mem[8'h51]}, 32'h77);
    check_value("rmid_m52", {24'd0, mem[8'h52]}, 32'h00);

    run_op(1'b1, 8'h00, 8'h50, 8'd5, 8'h3C, 1'b0);
    check_value("post_busy", busy_cnt, 32'd6);
    check_value("post_m54", {24'd0, mem[8'h54]}, 32'h3C);
    check_value("post_m55", {24'd0, mem[8'h55]}, 32'h00);

    $display("TB_RESULT checks=%0d failures=%0d", check_cnt, fail_cnt);
    $finish;
  end

endmodule
